// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared fetch-stage types and constants
package pipeline_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_t;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] WORD_BYTES = 32'd4;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - fetch stage: pc ownership, imem request/ready port, IF/ID presentation
module instruction_fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        hazard,
    input  logic        branchControlExInput,
    input  logic [31:0] branchTargetExInput,
    input  logic        jumpIdInput,
    input  logic [31:0] jumpTargetIdInput,
    output logic        imemReqOutput,
    output logic [31:0] imemAddrOutput,
    input  logic        imemReadyInput,
    input  logic [31:0] imemDataInput,
    output logic [31:0] pcOutput,
    output logic [31:0] instructionOutput
);

    fetch_state_t state, state_next;
    logic [31:0]  pcReg, pc_next;
    logic [31:0]  pendingReg, pending_next;
    logic [31:0]  bufInstr, buf_next;

    logic         redirect;
    logic [31:0]  target;

    // Branch is the older instruction, so it wins over a same-cycle jump.
    assign redirect = branchControlExInput | jumpIdInput;
    assign target   = word_align(branchControlExInput ? branchTargetExInput : jumpTargetIdInput);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            pcReg      <= RESET_PC;
            pendingReg <= 32'h0;
            bufInstr   <= NOP_INSTR;
        end else begin
            state      <= state_next;
            pcReg      <= pc_next;
            pendingReg <= pending_next;
            bufInstr   <= buf_next;
        end
    end

    always_comb begin
        state_next        = state;
        pc_next           = pcReg;
        pending_next      = pendingReg;
        buf_next          = bufInstr;
        imemReqOutput     = 1'b0;
        imemAddrOutput    = 32'h0;
        pcOutput          = 32'h0;
        instructionOutput = NOP_INSTR;

        case (state)
            IDLE: begin
                state_next = FETCH;
            end

            FETCH: begin
                imemReqOutput  = 1'b1;
                imemAddrOutput = pcReg;
                if (redirect) begin
                    // An in-flight request cannot be withdrawn; wait it out in DRAIN.
                    if (imemReadyInput) begin
                        pc_next = target;
                    end else begin
                        pending_next = target;
                        state_next   = DRAIN;
                    end
                end else if (imemReadyInput) begin
                    pcOutput          = pcReg + WORD_BYTES;
                    instructionOutput = imemDataInput;
                    if (hazard) begin
                        buf_next   = imemDataInput;
                        state_next = HOLD;
                    end else begin
                        pc_next = pcReg + WORD_BYTES;
                    end
                end
            end

            HOLD: begin
                pcOutput          = pcReg + WORD_BYTES;
                instructionOutput = bufInstr;
                if (redirect) begin
                    pc_next    = target;
                    state_next = FETCH;
                end else if (!hazard) begin
                    pc_next    = pcReg + WORD_BYTES;
                    state_next = FETCH;
                end
            end

            DRAIN: begin
                imemReqOutput  = 1'b1;
                imemAddrOutput = pcReg;
                if (redirect) begin
                    pending_next = target;
                end
                if (imemReadyInput) begin
                    pc_next    = redirect ? target : pendingReg;
                    state_next = FETCH;
                end
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - scoreboard bench for instruction_fetch
module tb_instruction_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        hazard;
    logic        branchControlExInput;
    logic [31:0] branchTargetExInput;
    logic        jumpIdInput;
    logic [31:0] jumpTargetIdInput;
    logic        imemReqOutput;
    logic [31:0] imemAddrOutput;
    logic        imemReadyInput;
    logic [31:0] imemDataInput;
    logic [31:0] pcOutput;
    logic [31:0] instructionOutput;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic        hz;
        logic        br;
        logic [31:0] bt;
        logic        jp;
        logic [31:0] jt;
        logic        rdy;
    } stim_t;

    typedef struct packed {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pc;
        logic [31:0] instr;
    } obs_t;

    stim_t stim_q[$];
    obs_t  exp_q[$];

    instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
        .clk                  (clk),
        .reset                (reset),
        .hazard               (hazard),
        .branchControlExInput (branchControlExInput),
        .branchTargetExInput  (branchTargetExInput),
        .jumpIdInput          (jumpIdInput),
        .jumpTargetIdInput    (jumpTargetIdInput),
        .imemReqOutput        (imemReqOutput),
        .imemAddrOutput       (imemAddrOutput),
        .imemReadyInput       (imemReadyInput),
        .imemDataInput        (imemDataInput),
        .pcOutput             (pcOutput),
        .instructionOutput    (instructionOutput)
    );

    always #5 clk = ~clk;

    task automatic push(input logic hz, input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt, input logic rdy,
                        input logic req, input logic [31:0] addr,
                        input logic [31:0] pc, input logic [31:0] instr);
        stim_q.push_back('{hz: hz, br: br, bt: bt, jp: jp, jt: jt, rdy: rdy});
        exp_q.push_back('{req: req, addr: addr, pc: pc, instr: instr});
    endtask

    // Memory answers with its own address as the instruction word; garbage when not ready.
    task automatic drive(input stim_t s);
        hazard               = s.hz;
        branchControlExInput = s.br;
        branchTargetExInput  = s.bt;
        jumpIdInput          = s.jp;
        jumpTargetIdInput    = s.jt;
        imemReadyInput       = s.rdy;
        imemDataInput        = s.rdy ? imemAddrOutput : 32'hDEAD_BEEF;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        drive('0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        drive('{hz: 1'b1, br: 1'b1, bt: 32'h40, jp: 1'b1, jt: 32'h80, rdy: 1'b1});
        @(posedge clk); #2;
        checks++;
        if ({imemReqOutput, imemAddrOutput, pcOutput, instructionOutput} !== 97'h0) begin
            errors++;
            $display("FAIL reset_outputs: got req=%0b addr=%h pc=%h instr=%h, expected all zero",
                     imemReqOutput, imemAddrOutput, pcOutput, instructionOutput);
        end
    endtask

    task automatic test_zero_wait();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0, 0, 0, 0,  0, 32'h0, 32'h0, 32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h0, 32'h4, 32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h4, 32'h8, 32'h4);
        push(0, 0, 0, 0, 0, 1,  1, 32'h8, 32'hC, 32'h8);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL zero_wait row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait2();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0, 0, 0, 0,  0, 32'h0, 32'h0, 32'h0);
        push(0, 0, 0, 0, 0, 0,  1, 32'h0, 32'h0, 32'h0);
        push(0, 0, 0, 0, 0, 0,  1, 32'h0, 32'h0, 32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h0, 32'h4, 32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h4, 32'h8, 32'h4);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL wait2 row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_hazard_hold();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0, 0, 0, 0,  0, 32'h0, 32'h0,  32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h0, 32'h4,  32'h0);
        push(0, 0, 0, 0, 0, 1,  1, 32'h4, 32'h8,  32'h4);
        push(1, 0, 0, 0, 0, 1,  1, 32'h8, 32'hC,  32'h8);
        push(1, 0, 0, 0, 0, 0,  0, 32'h0, 32'hC,  32'h8);
        push(1, 0, 0, 0, 0, 0,  0, 32'h0, 32'hC,  32'h8);
        push(0, 0, 0, 0, 0, 0,  0, 32'h0, 32'hC,  32'h8);
        push(0, 0, 0, 0, 0, 1,  1, 32'hC, 32'h10, 32'hC);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL hazard_hold row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch_drain();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0,       0, 0, 0,  0, 32'h0,   32'h0,   32'h0);
        push(0, 0, 0,       0, 0, 1,  1, 32'h0,   32'h4,   32'h0);
        push(0, 0, 0,       0, 0, 1,  1, 32'h4,   32'h8,   32'h4);
        push(0, 0, 0,       0, 0, 1,  1, 32'h8,   32'hC,   32'h8);
        push(0, 0, 0,       0, 0, 1,  1, 32'hC,   32'h10,  32'hC);
        push(0, 0, 0,       0, 0, 0,  1, 32'h10,  32'h0,   32'h0);
        push(0, 1, 32'h103, 0, 0, 0,  1, 32'h10,  32'h0,   32'h0);
        push(0, 0, 0,       0, 0, 0,  1, 32'h10,  32'h0,   32'h0);
        push(0, 0, 0,       0, 0, 1,  1, 32'h10,  32'h0,   32'h0);
        push(0, 0, 0,       0, 0, 1,  1, 32'h100, 32'h104, 32'h100);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL branch_drain row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_redirect_priority();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0,       0, 0,       0,  0, 32'h0,   32'h0,   32'h0);
        push(0, 0, 0,       0, 0,       1,  1, 32'h0,   32'h4,   32'h0);
        push(1, 1, 32'h200, 1, 32'h300, 1,  1, 32'h4,   32'h0,   32'h0);
        push(0, 0, 0,       0, 0,       1,  1, 32'h200, 32'h204, 32'h200);
        push(0, 0, 0,       1, 32'h301, 1,  1, 32'h204, 32'h0,   32'h0);
        push(0, 0, 0,       0, 0,       1,  1, 32'h300, 32'h304, 32'h300);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL redirect_priority row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_drain_and_wrap();
        obs_t o; obs_t e; int row = 0;
        do_reset();
        push(0, 0, 0,      0, 0, 0,  0, 32'h0, 32'h0, 32'h0);
        push(0, 0, 0,      0, 0, 0,  1, 32'h0, 32'h0, 32'h0);
        push(0, 1, 32'h40, 0, 0, 0,  1, 32'h0, 32'h0, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL pre_drain row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
        // Now in DRAIN with a live request; drop reset between clock edges.
        drive('0);
        reset = 1'b0;
        #1;
        checks++;
        if ({imemReqOutput, imemAddrOutput, pcOutput, instructionOutput} !== 97'h0) begin
            errors++;
            $display("FAIL async_reset_drain: got req=%0b addr=%h pc=%h instr=%h, expected all zero",
                     imemReqOutput, imemAddrOutput, pcOutput, instructionOutput);
        end
        @(posedge clk); #1;
        reset = 1'b1;
        row = 0;
        push(0, 0, 0, 0, 0,            0,  0, 32'h0,         32'h0, 32'h0);
        push(0, 0, 0, 0, 0,            1,  1, 32'h0,         32'h4, 32'h0);
        push(0, 0, 0, 1, 32'hFFFF_FFFE, 1, 1, 32'h4,         32'h0, 32'h0);
        push(0, 0, 0, 0, 0,            1,  1, 32'hFFFF_FFFC, 32'h0, 32'hFFFF_FFFC);
        push(0, 0, 0, 0, 0,            1,  1, 32'h0,         32'h4, 32'h0);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            drive(stim_q.pop_front()); #1;
            o = {imemReqOutput, imemAddrOutput, pcOutput, instructionOutput};
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL post_reset_wrap row %0d: got req=%0b addr=%h pc=%h instr=%h, expected req=%0b addr=%h pc=%h instr=%h",
                         row, o.req, o.addr, o.pc, o.instr, e.req, e.addr, e.pc, e.instr);
            end
            row++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_wait2();
        test_hazard_hold();
        test_branch_drain();
        test_redirect_priority();
        test_reset_mid_drain_and_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
